ils_instr_gen: RTL and testbench

//  Synthesizable constrained-random instruction source for the sodor5 ILS verification flow.

---
 rtl/ils_instr_gen_if.sv | 10 +
 rtl/ils_instr_gen.sv | 130 +++++++++++++
 tb/tb_ils_instr_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ils_instr_gen_if.sv
// Instruction stream handshake between the generator and its consumer.
interface ils_instr_gen_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  instr_cls;
  logic        instr_ready;

  modport master (output instr, instr_valid, instr_cls, input instr_ready);
  modport slave  (input instr, instr_valid, instr_cls, output instr_ready);
endinterface

// File: rtl/ils_instr_gen.sv
// LFSR-driven constrained-random RV32 instruction source (I-type ALU, LB/LBU, SB)
// with a NOP warm-up phase and valid/ready output handshake.
module ils_instr_gen #(
  parameter logic [31:0] SEED         = 32'h0000_0068,
  parameter int unsigned NUM_INSTR    = 1000,
  parameter int unsigned NOP_CYCLES   = 2,
  parameter bit          ENABLE_LOAD  = 1'b1,
  parameter bit          ENABLE_STORE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  ils_instr_gen_if.master   ib,
  output logic              done,
  output logic [31:0]       issued_cnt,
  output logic [31:0]       ld_cnt,
  output logic [31:0]       st_cnt
);

  localparam logic [31:0] SEED0 = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WARM, RUN, FIN} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  cls;
  } word_t;

  state_t      state_q, state_d;
  word_t       word_q, rnd;
  logic [31:0] lfsr_q, lfsr_nx;
  logic [31:0] nop_q;
  logic        hold_q;
  logic        valid, accept, load_rnd;

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ ({32{s[31]}} & 32'h0040_0007);
  endfunction

  // Next random word, computed from the current LFSR state
  always_comb begin
    logic [31:0] s1, s2;
    logic [44:0] r;
    logic [11:0] imm, imml;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3, f3l;
    logic [1:0]  ch;
    s1   = step(lfsr_q);
    s2   = step(s1);
    r    = {s1[12:0], s2};
    imm  = r[11:0];
    rs1  = r[16:12];
    rs2  = r[21:17];
    rd   = r[26:22];
    f3   = r[29:27];
    f3l  = {r[30], 2'b00};
    imml = r[42:31];
    ch   = r[44:43];
    if (f3 == 3'd5) imm = imm & 12'h41F;
    if (f3 == 3'd1) imm = imm & 12'h01F;
    lfsr_nx = s2;
    if (ch == 2'b01 && ENABLE_STORE)
      rnd = '{instr: {imml[11:5], rs2, rs1, 3'b000, imml[4:0], 7'b0100011}, cls: 2'd3};
    else if (ch == 2'b00 && ENABLE_LOAD)
      rnd = '{instr: {imml, rs1, f3l, rd, 7'b0000011}, cls: 2'd2};
    else
      rnd = '{instr: {imm, rs1, f3, rd, 7'b0010011}, cls: 2'd1};
  end

  // A word left unaccepted keeps valid high even if enable drops
  always_comb begin
    valid = 1'b0;
    case (state_q)
      WARM:    valid = 1'b1;
      RUN:     valid = enable | hold_q;
      FIN:     valid = 1'b1;
      default: valid = 1'b0;
    endcase
  end

  assign accept = valid & ib.instr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = (NOP_CYCLES != 0) ? WARM : RUN;
      WARM: if (accept && nop_q == 32'd1) state_d = RUN;
      RUN:  if (accept && NUM_INSTR != 0 && issued_cnt == NUM_INSTR - 32'd1) state_d = FIN;
      default: state_d = state_q;
    endcase
  end

  assign load_rnd = (state_d == RUN) &&
                    ((state_q != RUN) || accept);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_q     <= '{instr: NOP, cls: 2'd0};
      lfsr_q     <= SEED0;
      nop_q      <= '0;
      hold_q     <= 1'b0;
      issued_cnt <= '0;
      ld_cnt     <= '0;
      st_cnt     <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_q == RUN) && valid && !ib.instr_ready;
      if (load_rnd) begin
        word_q <= rnd;
        lfsr_q <= lfsr_nx;
      end else if (state_d == FIN) begin
        word_q <= '{instr: NOP, cls: 2'd0};
      end
      if (state_q == IDLE && enable) nop_q <= NOP_CYCLES;
      else if (state_q == WARM && accept) nop_q <= nop_q - 32'd1;
      if (state_q == RUN && accept) begin
        issued_cnt <= issued_cnt + 32'd1;
        if (word_q.cls == 2'd2) ld_cnt <= ld_cnt + 32'd1;
        if (word_q.cls == 2'd3) st_cnt <= st_cnt + 32'd1;
      end
    end
  end

  assign ib.instr       = word_q.instr;
  assign ib.instr_cls   = word_q.cls;
  assign ib.instr_valid = valid;
  assign done           = (state_q == FIN);

endmodule

// File: tb/tb_ils_instr_gen.sv
// Bench for ils_instr_gen: three configurations checked against an arithmetic
// model of the instruction-field rules.
module tb_ils_instr_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en_a = 0, en_b = 0, en_c = 0;
  logic done_a, done_b, done_c;
  logic [31:0] iss_a, ld_a, st_a, iss_b, ld_b, st_b, iss_c, ld_c, st_c;
  int errors = 0, checks = 0;
  logic [31:0] m_a, m_b, m_c;

  always #5 clk = ~clk;

  ils_instr_gen_if ifa();
  ils_instr_gen_if ifb();
  ils_instr_gen_if ifc();

  ils_instr_gen #(.NOP_CYCLES(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a), .ib(ifa),
    .done(done_a), .issued_cnt(iss_a), .ld_cnt(ld_a), .st_cnt(st_a));
  ils_instr_gen #(.NUM_INSTR(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b), .ib(ifb),
    .done(done_b), .issued_cnt(iss_b), .ld_cnt(ld_b), .st_cnt(st_b));
  ils_instr_gen #(.NUM_INSTR(0), .NOP_CYCLES(0), .ENABLE_LOAD(1'b0), .ENABLE_STORE(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(en_c), .ib(ifc),
    .done(done_c), .issued_cnt(iss_c), .ld_cnt(ld_c), .st_cnt(st_c));

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return (s << 1) ^ (s[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  // Reference: build the word from field arithmetic on the 64-bit random value
  task automatic model_word(input bit ld_en, input bit st_en, inout logic [31:0] st,
                            output logic [31:0] w, output logic [1:0] cls);
    longint unsigned r, imm, rs1, rs2, rd, f3, f3l, imml, ch, v;
    logic [31:0] s1, s2;
    s1 = nxt(st); s2 = nxt(s1); st = s2;
    r    = (longint'(s1) << 32) | longint'(s2);
    imm  = r & 64'hFFF;
    rs1  = (r >> 12) & 31;
    rs2  = (r >> 17) & 31;
    rd   = (r >> 22) & 31;
    f3   = (r >> 27) & 7;
    f3l  = ((r >> 30) & 1) * 4;
    imml = (r >> 31) & 64'hFFF;
    ch   = (r >> 43) & 3;
    if (f3 == 5) imm = imm & 64'h41F;
    if (f3 == 1) imm = imm & 64'h01F;
    if (ch == 1 && st_en) begin
      v = ((imml >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | ((imml & 31) << 7) | 64'h23;
      cls = 2'd3;
    end else if (ch == 0 && ld_en) begin
      v = (imml << 20) | (rs1 << 15) | (f3l << 12) | (rd << 7) | 64'h03;
      cls = 2'd2;
    end else begin
      v = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 64'h13;
      cls = 2'd1;
    end
    w = v[31:0];
  endtask

  task automatic test_reset;
    ifa.instr_ready = 0; ifb.instr_ready = 0; ifc.instr_ready = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ifa.instr_valid !== 1'b0 || ifa.instr !== 32'h13 || ifa.instr_cls !== 2'd0) begin
        errors++; $display("FAIL reset_idle_a: valid=%b instr=%h cls=%0d, want 0 00000013 0",
                           ifa.instr_valid, ifa.instr, ifa.instr_cls);
      end
    end
    checks++;
    if (iss_a !== 0 || ld_a !== 0 || st_a !== 0 || done_a !== 0 || ifb.instr_valid !== 0 ||
        iss_b !== 0 || done_b !== 0 || ifc.instr_valid !== 0 || iss_c !== 0) begin
      errors++; $display("FAIL reset_counters: iss_a=%0d ld_a=%0d st_a=%0d done_a=%b vb=%b iss_b=%0d vc=%b iss_c=%0d, want all 0",
                         iss_a, ld_a, st_a, done_a, ifb.instr_valid, iss_b, ifc.instr_valid, iss_c);
    end
  endtask

  task automatic test_warmup;
    int n = 0;
    logic [31:0] w; logic [1:0] c;
    m_a = 32'd104;
    en_a = 1; ifa.instr_ready = 1;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      @(posedge clk); #1;
      if (ifa.instr_valid && ifa.instr_ready) begin
        n++;
        checks++;
        if (n <= 3) begin
          if (ifa.instr !== 32'h13 || ifa.instr_cls !== 2'd0) begin
            errors++; $display("FAIL warm_nop%0d: instr=%h cls=%0d, want 00000013 cls 0", n, ifa.instr, ifa.instr_cls);
          end
        end else begin
          model_word(1, 1, m_a, w, c);
          if (ifa.instr !== w || ifa.instr_cls !== c) begin
            errors++; $display("FAIL warm_word%0d: instr=%h cls=%0d, want %h cls %0d", n, ifa.instr, ifa.instr_cls, w, c);
          end
        end
      end
    end
    checks++;
    if (n != 6 || iss_a !== 32'd2) begin
      errors++; $display("FAIL warm_count: accepted=%0d issued=%0d, want 6 and 2", n, iss_a);
    end
  endtask

  task automatic test_stall;
    logic [31:0] w, base; logic [1:0] c;
    @(posedge clk); #1;
    ifa.instr_ready = 0;
    model_word(1, 1, m_a, w, c);
    base = iss_a;
    checks++;
    if (ifa.instr !== w || base !== 32'd3) begin
      errors++; $display("FAIL stall_entry: instr=%h issued=%0d, want %h and 3", ifa.instr, base, w);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ifa.instr !== w || ifa.instr_cls !== c || ifa.instr_valid !== 1'b1 || iss_a !== base) begin
        errors++; $display("FAIL stall_hold%0d: instr=%h valid=%b issued=%0d, want %h 1 %0d",
                           i, ifa.instr, ifa.instr_valid, iss_a, w, base);
      end
    end
    ifa.instr_ready = 1;
    @(posedge clk); #1;
    model_word(1, 1, m_a, w, c);
    checks++;
    if (iss_a !== base + 1 || ifa.instr !== w) begin
      errors++; $display("FAIL stall_release: issued=%0d instr=%h, want %0d %h", iss_a, ifa.instr, base + 1, w);
    end
    // Idle enable drop: word stays pending, LFSR must not move
    en_a = 0; base = iss_a;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ifa.instr_valid !== 1'b0 || iss_a !== base) begin
        errors++; $display("FAIL en_drop%0d: valid=%b issued=%0d, want 0 %0d", i, ifa.instr_valid, iss_a, base);
      end
    end
    en_a = 1; #1;
    checks++;
    if (ifa.instr_valid !== 1'b1 || ifa.instr !== w) begin
      errors++; $display("FAIL en_return: valid=%b instr=%h, want 1 %h", ifa.instr_valid, ifa.instr, w);
    end
    // Enable drop while a stalled word is pending: valid must persist
    ifa.instr_ready = 0;
    @(posedge clk); #1;
    en_a = 0; #1;
    checks++;
    if (ifa.instr_valid !== 1'b1 || ifa.instr !== w) begin
      errors++; $display("FAIL pend_hold: valid=%b instr=%h, want 1 %h", ifa.instr_valid, ifa.instr, w);
    end
    ifa.instr_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (ifa.instr_valid !== 1'b0 || iss_a !== base + 1) begin
      errors++; $display("FAIL pend_accept: valid=%b issued=%0d, want 0 %0d", ifa.instr_valid, iss_a, base + 1);
    end
  endtask

  task automatic test_done;
    int n = 0, nld = 0, nst = 0;
    logic [31:0] w; logic [1:0] c;
    m_b = 32'd104;
    en_b = 1; ifb.instr_ready = 1;
    for (int cyc = 0; cyc < 40 && !done_b; cyc++) begin
      @(posedge clk); #1;
      if (!done_b && ifb.instr_valid && ifb.instr_cls !== 2'd0) begin
        n++;
        model_word(1, 1, m_b, w, c);
        if (c == 2'd2) nld++;
        if (c == 2'd3) nst++;
        checks++;
        if (ifb.instr !== w || ifb.instr_cls !== c) begin
          errors++; $display("FAIL done_word%0d: instr=%h cls=%0d, want %h cls %0d", n, ifb.instr, ifb.instr_cls, w, c);
        end
      end
    end
    checks++;
    if (done_b !== 1'b1 || n != 4 || ifb.instr !== 32'h13 || ifb.instr_cls !== 2'd0 ||
        ifb.instr_valid !== 1'b1 || iss_b !== 32'd4) begin
      errors++; $display("FAIL done_state: done=%b words=%0d instr=%h cls=%0d valid=%b issued=%0d, want 1 4 00000013 0 1 4",
                         done_b, n, ifb.instr, ifb.instr_cls, ifb.instr_valid, iss_b);
    end
    checks++;
    if (ld_b !== nld || st_b !== nst) begin
      errors++; $display("FAIL done_classes: ld=%0d st=%0d, want %0d %0d", ld_b, st_b, nld, nst);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_b !== 1'b1 || iss_b !== 32'd4 || ifb.instr !== 32'h13) begin
      errors++; $display("FAIL done_sticky: done=%b issued=%0d instr=%h, want 1 4 00000013", done_b, iss_b, ifb.instr);
    end
  endtask

  task automatic test_no_ldst;
    int n = 0;
    logic [31:0] w; logic [1:0] c;
    m_c = 32'd104;
    en_c = 1; ifc.instr_ready = 0;
    for (int cyc = 0; cyc < 10000 && n < 1000; cyc++) begin
      @(posedge clk); #1;
      ifc.instr_ready = 1'($urandom_range(0, 1));
      if (ifc.instr_valid && ifc.instr_ready) begin
        n++;
        model_word(0, 0, m_c, w, c);
        checks++;
        if (ifc.instr !== w || ifc.instr_cls !== 2'd1 || ifc.instr[6:0] !== 7'b0010011) begin
          errors++; $display("FAIL itype_word%0d: instr=%h cls=%0d, want %h cls 1", n, ifc.instr, ifc.instr_cls, w);
        end
        if (ifc.instr[14:12] == 3'd5) begin
          checks++;
          if (ifc.instr[31] !== 1'b0 || ifc.instr[29:25] !== 5'd0) begin
            errors++; $display("FAIL srai_imm%0d: imm=%h, want bits 11 and 9:5 zero", n, ifc.instr[31:20]);
          end
        end
        if (ifc.instr[14:12] == 3'd1) begin
          checks++;
          if (ifc.instr[31:25] !== 7'd0) begin
            errors++; $display("FAIL slli_imm%0d: imm=%h, want bits 11:5 zero", n, ifc.instr[31:20]);
          end
        end
      end
    end
    @(posedge clk); #1;
    ifc.instr_ready = 0;
    checks++;
    if (n != 1000 || iss_c !== 32'd1000 || ld_c !== 0 || st_c !== 0 || done_c !== 0) begin
      errors++; $display("FAIL itype_totals: words=%0d issued=%0d ld=%0d st=%0d done=%b, want 1000 1000 0 0 0",
                         n, iss_c, ld_c, st_c, done_c);
    end
  endtask

  task automatic run_a_words(input int k, input int pass);
    int n = 0;
    logic [31:0] w; logic [1:0] c;
    for (int cyc = 0; cyc < 400 && n < k; cyc++) begin
      @(posedge clk); #1;
      ifa.instr_ready = 1'($urandom_range(0, 1));
      if (ifa.instr_valid && ifa.instr_ready && ifa.instr_cls !== 2'd0) begin
        n++;
        model_word(1, 1, m_a, w, c);
        checks++;
        if (ifa.instr !== w || ifa.instr_cls !== c) begin
          errors++; $display("FAIL restart_p%0d_w%0d: instr=%h cls=%0d, want %h cls %0d",
                             pass, n, ifa.instr, ifa.instr_cls, w, c);
        end
      end
    end
    checks++;
    if (n != k) begin
      errors++; $display("FAIL restart_p%0d_timeout: words=%0d, want %0d", pass, n, k);
    end
  endtask

  task automatic test_reset_restart;
    en_a = 1;
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #3;
      reset_n = 0; #1;
      checks++;
      if (ifa.instr_valid !== 1'b0 || ifa.instr !== 32'h13 || iss_a !== 0) begin
        errors++; $display("FAIL restart_abort%0d: valid=%b instr=%h issued=%0d, want 0 00000013 0",
                           pass, ifa.instr_valid, ifa.instr, iss_a);
      end
      @(posedge clk); #1;
      reset_n = 1;
      m_a = 32'd104;
      run_a_words(7, pass);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_stall();
    test_done();
    test_no_ldst();
    test_reset_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
